alu_seq: RTL and testbench

- Execution-stage ALU that consumes the 4-bit ALUctl code from the ALU control decoder, plus operands A and B.
- Single-cycle ops (and/or/add/sub/slt/nor/xor) return a registered result one cycle after start.
- mult runs an iterative signed shift-add multiply over WIDTH cycles and writes a 2*WIDTH product into HI/LO.
- Handshake is start/busy/done, so the pipeline stalls on mult.

---
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execution-stage ALU: single-cycle ops plus iterative signed shift-add multiply into hi/lo
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1111;
    localparam logic [3:0] OP_MULT = 4'b1000;

    typedef enum logic [1:0] {IDLE, MUL, SIGN} state_t;
    state_t state, state_next;

    logic [2*WIDTH-1:0] acc, mcand, prod;
    logic [WIDTH-1:0]   mplier, abs_a, abs_b, sum, diff, alu_res;
    logic [CW-1:0]      count;
    logic               sign, alu_ovf, alu_ill;

    // Magnitudes are taken unsigned, so the most-negative value maps to 2^(W-1) correctly.
    assign abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;
    assign sum   = A + B;
    assign diff  = A - B;
    assign prod  = sign ? (~acc + 1'b1) : acc;
    assign busy  = (state != IDLE);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ALUctl)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_NOR: alu_res = ~(A | B);
            OP_XOR: alu_res = A ^ B;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && ALUctl == OP_MULT) state_next = MUL;
            MUL:  if (count == CW'(WIDTH - 1)) state_next = SIGN;
            SIGN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            hi       <= '0;
            lo       <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            done     <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            sign     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (ALUctl == OP_MULT) begin
                        mcand  <= {{WIDTH{1'b0}}, abs_a};
                        mplier <= abs_b;
                        sign   <= A[WIDTH-1] ^ B[WIDTH-1];
                        acc    <= '0;
                        count  <= '0;
                    end else begin
                        result   <= alu_res;
                        zero     <= (alu_res == '0);
                        overflow <= alu_ovf;
                        illegal  <= alu_ill;
                        done     <= 1'b1;
                    end
                end
                MUL: begin
                    // Multiplicand is pre-shifted each step, equivalent to shifting by the counter.
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                end
                SIGN: begin
                    hi       <= prod[2*WIDTH-1:WIDTH];
                    lo       <= prod[WIDTH-1:0];
                    result   <= prod[WIDTH-1:0];
                    zero     <= (prod[WIDTH-1:0] == '0);
                    overflow <= 1'b0;
                    illegal  <= 1'b0;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;
    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   ALUctl = 4'h0;
    logic [W-1:0] A = '0, B = '0;
    logic [W-1:0] result, hi, lo;
    logic         zero, overflow, illegal, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0, last_res = '0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUctl(ALUctl), .A(A), .B(B),
        .result(result), .hi(hi), .lo(lo), .zero(zero), .overflow(overflow),
        .illegal(illegal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic ovf, output logic ill);
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; ovf = 1'b0; ill = 1'b0;
        case (ctl)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin t = sa + sb; r = t[31:0]; ovf = (t > MAXS) || (t < MINS); end
            4'h6: begin t = sa - sb; r = t[31:0]; ovf = (t > MAXS) || (t < MINS); end
            4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'hC: r = ~(a | b);
            4'hF: r = a ^ b;
            default: ill = 1'b1;
        endcase
    endfunction

    // Issue one non-mult op; the result is checked one edge later, leaving done high so the
    // next call starts on the very edge that done is visible.
    task automatic do_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r; logic ovf, ill;
        model_op(ctl, a, b, r, ovf, ill);
        @(negedge clk); ALUctl = ctl; A = a; B = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("op_done", done, 1);
        check("op_result", result, r);
        check("op_zero", zero, r == 0);
        check("op_ovf", overflow, ovf);
        check("op_illegal", illegal, ill);
        check("op_hi", hi, exp_hi);
        check("op_lo", lo, exp_lo);
        last_res = r;
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_hold", result, last_res);
    endtask

    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at);
        longint p; int n; int busy_cnt;
        p = longint'($signed(a)) * longint'($signed(b));
        @(negedge clk); ALUctl = 4'b1000; A = a; B = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1; busy_cnt = 0;
        check("mul_busy", busy, 1);
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            if (n == inject_at) begin ALUctl = 4'h0; A = 32'hF; B = 32'hF; start = 1'b1; end
            @(posedge clk); #1 start = 1'b0;
            n++;
        end
        check("mul_latency", n, W + 2);
        check("mul_busy_cycles", busy_cnt, W + 1);
        exp_hi = p[63:32]; exp_lo = p[31:0]; last_res = p[31:0];
        check("mul_hi", hi, exp_hi);
        check("mul_lo", lo, exp_lo);
        check("mul_result", result, exp_lo);
        check("mul_zero", zero, exp_lo == 0);
        check("mul_ovf", overflow, 0);
        check("mul_busy_end", busy, 0);
        @(posedge clk); #1;
        check("mul_single_done", done, 0);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h80000000;
            1: return 32'h7FFFFFFF;
            2: return 32'($urandom_range(0, 3));
            3: return 32'hFFFFFFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    logic [3:0] legal_codes [7] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hF};
    logic [3:0] bad_codes   [8] = '{4'h3, 4'h4, 4'h5, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};

    initial begin
        #12;
        check("rst_result", result, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_zero", zero, 1);
        check("rst_ovf", overflow, 0);
        check("rst_illegal", illegal, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk); rst_n = 1'b1;

        do_op(4'b0010, 32'h7FFFFFFF, 32'h1);
        idle_check();
        do_op(4'b0110, 32'd5, 32'd5);
        do_op(4'b0111, 32'hFFFFFFFF, 32'd1);
        idle_check();
        do_mult(32'hFFFFFFFD, 32'd7, -1);
        do_mult(32'hFFFFFFFD, 32'd7, 10);
        do_op(4'b0101, 32'h1234, 32'h5678);
        idle_check();
        do_mult(32'h80000000, 32'h80000000, -1);
        do_mult(32'h0, 32'h12345678, -1);
        do_mult(32'h80000000, 32'h1, -1);

        // Reset in the middle of a multiply
        @(negedge clk); ALUctl = 4'b1000; A = 32'd99; B = 32'd77; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_hi", hi, 0);
        check("rstmid_lo", lo, 0);
        check("rstmid_result", result, 0);
        check("rstmid_zero", zero, 1);
        check("rstmid_done", done, 0);
        exp_hi = '0; exp_lo = '0; last_res = '0;
        @(negedge clk); rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            check("rstmid_no_done", done, 0);
        end
        do_op(4'b0010, 32'd20, 32'd22);
        idle_check();

        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 11);
            if (sel == 0)
                do_mult(rand_operand(), rand_operand(), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : -1);
            else if (sel == 1)
                do_op(bad_codes[$urandom_range(0, 7)], rand_operand(), rand_operand());
            else
                do_op(legal_codes[$urandom_range(0, 6)], rand_operand(), rand_operand());
        end
        idle_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
